// File: rtl/data_path.sv
// data_path: 8-bit register file, bus muxes and flag-producing ALU behind the control unit
module data_path #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [3:0] CCR_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IR_Load,
  input  logic       MAR_Load,
  input  logic       PC_Load,
  input  logic       PC_Inc,
  input  logic       A_Load,
  input  logic       B_Load,
  input  logic [3:0] ALU_Sel,
  input  logic       CCR_Load,
  input  logic [1:0] Bus1_Sel,
  input  logic [1:0] Bus2_Sel,
  input  logic [7:0] from_memory,
  output logic [7:0] address,
  output logic [7:0] to_memory,
  output logic [7:0] IR,
  output logic [3:0] CCR_Result
);
  logic [7:0] pc, mar, a, b, bus1, bus2, opd, res;
  logic [8:0] sum, diff;
  logic       c, v;
  assign bus1 = Bus1_Sel == 2'b00 ? pc : Bus1_Sel == 2'b01 ? a : Bus1_Sel == 2'b10 ? b : 8'h00;
  assign bus2 = Bus2_Sel == 2'b00 ? res : Bus2_Sel == 2'b01 ? bus1 : Bus2_Sel == 2'b10 ? from_memory : 8'h00;
  assign opd = ALU_Sel == 4'd0 || ALU_Sel == 4'd1 ? b : 8'h01;
  assign sum = {1'b0, bus1} + {1'b0, opd};
  assign diff = {1'b0, bus1} - {1'b0, opd};
  always_comb begin
    res = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (ALU_Sel)
      4'd0, 4'd7, 4'd8: begin
        res = sum[7:0];
        c = sum[8];
        v = bus1[7] == opd[7] && res[7] != bus1[7];
      end
      4'd1, 4'd9, 4'd10: begin
        res = diff[7:0];
        c = diff[8];
        v = bus1[7] != opd[7] && res[7] != bus1[7];
      end
      4'd2: res = {7'd0, |bus1 && |b};
      4'd3: res = {7'd0, |bus1 || |b};
      4'd4: res = bus1 & b;
      4'd5: res = bus1 | b;
      4'd6: res = bus1 ^ b;
      default: res = 8'h00;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= PC_RESET;
      mar <= 8'h00;
      IR <= 8'h00;
      a <= 8'h00;
      b <= 8'h00;
      CCR_Result <= CCR_RESET;
    end else begin
      pc <= PC_Load ? bus2 : PC_Inc ? pc + 8'd1 : pc;
      if (MAR_Load) mar <= bus2;
      if (IR_Load) IR <= bus2;
      if (A_Load) a <= bus2;
      if (B_Load) b <= bus2;
      if (CCR_Load) CCR_Result <= {c, res == 8'h00, res[7], v};
    end
  assign address = mar;
  assign to_memory = bus1;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed vectors with hand-computed expectations for data_path
module tb_data_path;
  logic       clk = 1'b0, reset = 1'b0;
  logic       IR_Load = 0, MAR_Load = 0, PC_Load = 0, PC_Inc = 0, A_Load = 0, B_Load = 0, CCR_Load = 0;
  logic [3:0] ALU_Sel = 4'd0;
  logic [1:0] Bus1_Sel = 2'b00, Bus2_Sel = 2'b00;
  logic [7:0] from_memory = 8'h00;
  logic [7:0] address, to_memory, IR;
  logic [3:0] CCR_Result;
  int passed = 0, total = 0;
  data_path dut (
    .clk(clk), .reset(reset), .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load),
    .PC_Inc(PC_Inc), .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .from_memory(from_memory), .address(address),
    .to_memory(to_memory), .IR(IR), .CCR_Result(CCR_Result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic peek(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    Bus1_Sel = sel;
    #1;
    chk(tag, to_memory, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = '0;
  endtask
  task automatic mem(input logic [7:0] v);
    from_memory = v;
    Bus2_Sel = 2'b10;
  endtask
  task automatic alu(input logic [3:0] op, input logic [1:0] src);
    ALU_Sel = op;
    Bus1_Sel = src;
    Bus2_Sel = 2'b00;
    CCR_Load = 1;
  endtask
  initial begin
    #1;
    chk("rst_addr", address, 8'h00);
    chk("rst_ir", IR, 8'h00);
    chk("rst_ccr", {4'h0, CCR_Result}, 8'h00);
    peek("rst_pc", 2'b00, 8'h00);
    @(posedge clk);
    #1 reset = 1;
    mem(8'h55); A_Load = 1; IR_Load = 1; MAR_Load = 1; cyc();
    mem(8'h10); PC_Load = 1; cyc();
    alu(4'd15, 2'b11); cyc();
    peek("pre_a", 2'b01, 8'h55);
    peek("pre_pc", 2'b00, 8'h10);
    chk("pre_ir", IR, 8'h55);
    chk("pre_addr", address, 8'h55);
    chk("rsv_ccr", {4'h0, CCR_Result}, 8'h04);
    reset = 0;
    #1;
    chk("mid_addr", address, 8'h00);
    chk("mid_ir", IR, 8'h00);
    chk("mid_ccr", {4'h0, CCR_Result}, 8'h00);
    peek("mid_pc", 2'b00, 8'h00);
    peek("mid_a", 2'b01, 8'h00);
    peek("mid_b", 2'b10, 8'h00);
    mem(8'h77); A_Load = 1; PC_Inc = 1; cyc();
    peek("hold_a", 2'b01, 8'h00);
    peek("hold_pc", 2'b00, 8'h00);
    reset = 1;
    from_memory = 8'h86; Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; MAR_Load = 1; PC_Inc = 1; cyc();
    chk("fetch_mar", address, 8'h00);
    peek("fetch_pc", 2'b00, 8'h01);
    Bus2_Sel = 2'b10; IR_Load = 1; cyc();
    chk("fetch_ir", IR, 8'h86);
    Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; MAR_Load = 1; cyc();
    chk("mar_pc1", address, 8'h01);
    mem(8'h7F); A_Load = 1; cyc();
    mem(8'h01); B_Load = 1; cyc();
    alu(4'd0, 2'b01); A_Load = 1; cyc();
    peek("add_a", 2'b01, 8'h80);
    chk("add_ccr", {4'h0, CCR_Result}, 8'h03);
    peek("add_b", 2'b10, 8'h01);
    mem(8'h05); A_Load = 1; B_Load = 1; cyc();
    alu(4'd1, 2'b01); A_Load = 1; cyc();
    peek("sub0_a", 2'b01, 8'h00);
    chk("sub0_ccr", {4'h0, CCR_Result}, 8'h04);
    mem(8'h01); B_Load = 1; cyc();
    alu(4'd1, 2'b01); A_Load = 1; cyc();
    peek("subb_a", 2'b01, 8'hFF);
    chk("subb_ccr", {4'h0, CCR_Result}, 8'h0A);
    alu(4'd15, 2'b01); cyc();
    chk("rsv2_ccr", {4'h0, CCR_Result}, 8'h04);
    mem(8'h00); B_Load = 1; cyc();
    alu(4'd10, 2'b10); B_Load = 1; cyc();
    peek("decb_b", 2'b10, 8'hFF);
    chk("decb_ccr", {4'h0, CCR_Result}, 8'h0A);
    peek("decb_a", 2'b01, 8'hFF);
    mem(8'h0F); A_Load = 1; cyc();
    alu(4'd6, 2'b01); A_Load = 1; cyc();
    peek("xor_a", 2'b01, 8'hF0);
    chk("xor_ccr", {4'h0, CCR_Result}, 8'h02);
    alu(4'd7, 2'b10); B_Load = 1; cyc();
    peek("inc_b", 2'b10, 8'h00);
    chk("inc_ccr", {4'h0, CCR_Result}, 8'h0C);
    alu(4'd2, 2'b01); A_Load = 1; cyc();
    peek("land_a", 2'b01, 8'h00);
    chk("land_ccr", {4'h0, CCR_Result}, 8'h04);
    mem(8'hFF); PC_Load = 1; cyc();
    PC_Inc = 1; cyc();
    peek("pc_wrap", 2'b00, 8'h00);
    mem(8'h40); PC_Load = 1; PC_Inc = 1; cyc();
    peek("pc_prio", 2'b00, 8'h40);
    mem(8'h3C); B_Load = 1; cyc();
    peek("tomem_b", 2'b10, 8'h3C);
    peek("bus1_rsv", 2'b11, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
